// File: rtl/painter_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : painter_top
// Brief    : 640x480@60 VGA painter. Eight vertical colour bars with a
//            bouncing white square, 3-bit RGB plus active-low syncs.
//            Pixel rate is clk/2 via an internal toggle enable.
// Options  : `define BORDER_EN adds a one-pixel red frame around the
//            visible area (square > border > bars).
// Revision : 1.0 - initial release
// ============================================================================
module painter_top #(
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33,
   parameter int SQ_SIZE = 32
) (
   input  logic       clk,
   input  logic       reset,   // asynchronous, active low
   output logic [2:0] color,
   output logic       hsync,
   output logic       vsync
);

   // ------------------------------------------------------------------------
   // Derived timing constants (all counters are 10 bits wide)
   // ------------------------------------------------------------------------
   localparam int         c_H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int         c_V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int         c_BAR_W    = H_VIS / 8;
   localparam logic [9:0] c_H_MAX    = 10'(c_H_TOTAL - 1);
   localparam logic [9:0] c_V_MAX    = 10'(c_V_TOTAL - 1);
   localparam logic [9:0] c_H_VIS    = 10'(H_VIS);
   localparam logic [9:0] c_V_VIS    = 10'(V_VIS);
   localparam logic [9:0] c_HS_FIRST = 10'(H_VIS + H_FP);
   localparam logic [9:0] c_HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] c_VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0] c_VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [9:0] c_SQ       = 10'(SQ_SIZE);
   localparam logic [9:0] c_X_MAX    = 10'(H_VIS - SQ_SIZE);
   localparam logic [9:0] c_Y_MAX    = 10'(V_VIS - SQ_SIZE);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic       pix_q,   pix_d;      // pixel enable toggle; high = pixel tick
   logic [9:0] h_q,     h_d;
   logic [9:0] v_q,     v_d;
   logic [9:0] sx_q,    sx_d;       // square top-left corner
   logic [9:0] sy_q,    sy_d;
   logic       dx_q,    dx_d;       // 1 = moving right, 0 = moving left
   logic       dy_q,    dy_d;       // 1 = moving down,  0 = moving up
   logic [2:0] color_q, color_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;

   // Combinational helpers
   logic       frame_end;
   logic       visible;
   logic       in_square;
   logic       on_border;
   logic [2:0] bar_idx;

   assign color = color_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

   // Pixel enable and raster counters: h wraps each line, v steps on h wrap
   always_comb begin
      pix_d = ~pix_q;
      h_d   = h_q;
      v_d   = v_q;
      if (pix_q) begin
         if (h_q == c_H_MAX) begin
            h_d = '0;
            if (v_q == c_V_MAX) begin
               v_d = '0;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   // Last pixel tick of the frame: the square moves here so the new
   // position is in effect from the first pixel of the next frame
   assign frame_end = pix_q && (h_q == c_H_MAX) && (v_q == c_V_MAX);

   // Square motion: one pixel per frame per axis, reflecting at the edges
   always_comb begin
      sx_d = sx_q;
      sy_d = sy_q;
      dx_d = dx_q;
      dy_d = dy_q;
      if (frame_end) begin
         // X axis
         if (dx_q) begin
            if (sx_q == c_X_MAX) begin
               dx_d = 1'b0;
               sx_d = c_X_MAX - 10'd1;
            end else begin
               sx_d = sx_q + 10'd1;
            end
         end else begin
            if (sx_q == 10'd0) begin
               dx_d = 1'b1;
               sx_d = 10'd1;
            end else begin
               sx_d = sx_q - 10'd1;
            end
         end
         // Y axis
         if (dy_q) begin
            if (sy_q == c_Y_MAX) begin
               dy_d = 1'b0;
               sy_d = c_Y_MAX - 10'd1;
            end else begin
               sy_d = sy_q + 10'd1;
            end
         end else begin
            if (sy_q == 10'd0) begin
               dy_d = 1'b1;
               sy_d = 10'd1;
            end else begin
               sy_d = sy_q - 10'd1;
            end
         end
      end
   end

   // Bar index as a comparator chain against multiples of the bar width
   always_comb begin
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (h_q >= 10'(k * c_BAR_W)) begin
            bar_idx = 3'(k);
         end
      end
   end

   assign visible   = (h_q < c_H_VIS) && (v_q < c_V_VIS);
   assign in_square = (h_q >= sx_q) && (h_q < sx_q + c_SQ) &&
                      (v_q >= sy_q) && (v_q < sy_q + c_SQ);
`ifdef BORDER_EN
   assign on_border = (h_q == 10'd0) || (h_q == c_H_VIS - 10'd1) ||
                      (v_q == 10'd0) || (v_q == c_V_VIS - 10'd1);
`else
   assign on_border = 1'b0;
`endif

   // Output pixel: colour priority and sync windows from the current h,v
   always_comb begin
      color_d = color_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      if (pix_q) begin
         if (!visible) begin
            color_d = 3'b000;
         end else if (in_square) begin
            color_d = 3'b111;
         end else if (on_border) begin
            color_d = 3'b100;
         end else begin
            color_d = bar_idx;
         end
         hsync_d = !((h_q >= c_HS_FIRST) && (h_q <= c_HS_LAST));
         vsync_d = !((v_q >= c_VS_FIRST) && (v_q <= c_VS_LAST));
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_q   <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         color_q <= 3'b000;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         pix_q   <= pix_d;
         h_q     <= h_d;
         v_q     <= v_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         color_q <= color_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_painter_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_painter_top
// Brief    : Self-checking bench for painter_top. A full-size instance and a
//            scaled-down instance share clock and reset; every pixel tick of
//            both is compared against a closed-form model of the raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_painter_top;

   // Scaled-down geometry so many frames (and square bounces) fit in a short run
   localparam int S_HV  = 32;
   localparam int S_HFP = 2;
   localparam int S_HS  = 4;
   localparam int S_HBP = 2;
   localparam int S_VV  = 16;
   localparam int S_VFP = 1;
   localparam int S_VS  = 2;
   localparam int S_VBP = 1;
   localparam int S_SQ  = 8;
   localparam int S_FRAME_TICKS = (S_HV + S_HFP + S_HS + S_HBP) *
                                  (S_VV + S_VFP + S_VS + S_VBP);

   logic       clk;
   logic       reset;
   logic [2:0] f_color, s_color;
   logic       f_hs, f_vs, s_hs, s_vs;

   int checks = 0;
   int errors = 0;
   int t      = 0;     // pixel ticks since the first enabled edge after release

   initial clk = 1'b0;
   always #10 clk = ~clk;   // 50 MHz

   painter_top u_full (
      .clk   (clk),
      .reset (reset),
      .color (f_color),
      .hsync (f_hs),
      .vsync (f_vs)
   );

   painter_top #(
      .H_VIS (S_HV), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
      .V_VIS (S_VV), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
      .SQ_SIZE (S_SQ)
   ) u_small (
      .clk   (clk),
      .reset (reset),
      .color (s_color),
      .hsync (s_hs),
      .vsync (s_vs)
   );

   // Square coordinate after f frame updates: triangle wave between 0 and lim
   function automatic int bounce(input int f, input int lim);
      int p;
      p = f % (2 * lim);
      return (p <= lim) ? p : (2 * lim - p);
   endfunction

   // Expected {color, hsync, vsync} registered after pixel tick tk
   function automatic logic [4:0] model(input int tk, input int hv, hfp, hs, hbp,
                                        input int vv, vfp, vs, vbp, sq);
      int htot, vtot, f, pos, h, v, sx, sy;
      logic [2:0] c;
      logic hsn, vsn;
      htot = hv + hfp + hs + hbp;
      vtot = vv + vfp + vs + vbp;
      f    = tk / (htot * vtot);
      pos  = tk % (htot * vtot);
      h    = pos % htot;
      v    = pos / htot;
      sx   = bounce(f, hv - sq);
      sy   = bounce(f, vv - sq);
      if (h >= hv || v >= vv)
         c = 3'b000;
      else if (h >= sx && h < sx + sq && v >= sy && v < sy + sq)
         c = 3'b111;
`ifdef BORDER_EN
      else if (h == 0 || h == hv - 1 || v == 0 || v == vv - 1)
         c = 3'b100;
`endif
      else
         c = 3'(h / (hv / 8));
      hsn = !((h >= hv + hfp) && (h < hv + hfp + hs));
      vsn = !((v >= vv + vfp) && (v < vv + vfp + vs));
      return {c, hsn, vsn};
   endfunction

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed={color,hs,vs}=%b required=%b", tag, t, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_full"},  {f_color, f_hs, f_vs}, 5'b000_11);
      check({tag, "_small"}, {s_color, s_hs, s_vs}, 5'b000_11);
   endtask

   task automatic check_tick();
      check("pix_full",  {f_color, f_hs, f_vs}, model(t, 640, 16, 96, 48, 480, 10, 2, 33, 32));
      check("pix_small", {s_color, s_hs, s_vs},
            model(t, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, S_SQ));
   endtask

   // Each tick: enabled edge, sample; idle edge, sample again (must hold)
   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_tick();
         @(posedge clk);
         @(negedge clk);
         check_tick();
         t++;
      end
   endtask

   // Called at a negedge with reset low: release, then one non-pixel edge
   task automatic release_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("first_edge");
      t = 0;
   endtask

   initial begin
      int hold;
      reset = 1'b1;
      #5 reset = 1'b0;

      // Hold reset ~10 us; outputs must sit at reset values throughout
      hold = $urandom_range(500, 520);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_reset_vals("rst_hold");
      end

      // 28 small frames: covers y bounce at both ends and x bounce at the right
      release_reset();
      run_ticks(28 * S_FRAME_TICKS);

      // Reset in the middle of a visible part of a frame
      run_ticks($urandom_range(S_FRAME_TICKS / 20 + 1, S_FRAME_TICKS * 3 / 4));
      reset = 1'b0;
      #1 check_reset_vals("async_rst");
      hold = $urandom_range(3, 20);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_reset_vals("mid_rst_hold");
      end

      // Restart: square back at origin, raster from h=0, v=0
      release_reset();
      run_ticks(2 * S_FRAME_TICKS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
